// File: rtl/celltest_pkg.sv
// Slot table, cell types and the ideal-logic helpers shared by the cell test sequencer.
package celltest_pkg;

    typedef enum logic [1:0] {CT_NOT, CT_NAND, CT_NOR} cell_t;

    typedef struct packed {
        cell_t           ctype;
        logic [2:0]      n_inputs;
        logic [3:0][6:0] in_pin;   // in_pin[i] is header pin of input A(i+1)
        logic [6:0]      out_pin;
    } slot_t;

    localparam int NUM_SLOTS   = 17;
    localparam int NUM_VECTORS = 88;

    // Every gate on the board uses consecutive pins: inputs first, output last.
    function automatic slot_t mk_slot(cell_t ct, int n, int first);
        slot_t s;
        s.ctype    = ct;
        s.n_inputs = 3'(n);
        s.in_pin   = '0;
        for (int i = 0; i < 4; i++)
            if (i < n) s.in_pin[i] = 7'(first + i);
        s.out_pin  = 7'(first + n);
        return s;
    endfunction

    localparam slot_t SLOT_TAB [NUM_SLOTS] = '{
        mk_slot(CT_NOT, 1, 1),   mk_slot(CT_NOT, 1, 3),
        mk_slot(CT_NOT, 1, 5),   mk_slot(CT_NOT, 1, 7),
        mk_slot(CT_NAND, 2, 9),  mk_slot(CT_NAND, 2, 12),
        mk_slot(CT_NAND, 2, 15), mk_slot(CT_NAND, 2, 18),
        mk_slot(CT_NOR, 2, 21),  mk_slot(CT_NOR, 2, 24),
        mk_slot(CT_NOR, 2, 27),  mk_slot(CT_NOR, 2, 30),
        mk_slot(CT_NAND, 3, 33), mk_slot(CT_NAND, 3, 37),
        mk_slot(CT_NOR, 3, 41),  mk_slot(CT_NOR, 3, 45),
        mk_slot(CT_NAND, 4, 49)
    };

    // Vector bits above n_inputs are always zero, so NOR needs no masking.
    function automatic logic expected_out(cell_t ct, logic [2:0] n, logic [3:0] vec);
        case (ct)
            CT_NOT:  return ~vec[0];
            CT_NAND: return vec != ((4'd1 << n) - 4'd1);
            default: return vec == 4'd0;
        endcase
    endfunction

    function automatic logic [64:1] input_mask();
        logic [64:1] m;
        m = '0;
        for (int s = 0; s < NUM_SLOTS; s++)
            for (int i = 0; i < 4; i++)
                if (i < int'(SLOT_TAB[s].n_inputs)) m[SLOT_TAB[s].in_pin[i]] = 1'b1;
        return m;
    endfunction

    function automatic logic [64:1] vec_drive(logic [3:0][6:0] pins, logic [2:0] n,
                                              logic [3:0] vec);
        logic [64:1] d;
        d = '0;
        for (int i = 0; i < 4; i++)
            if (i < int'(n)) d[pins[i]] = vec[i];
        return d;
    endfunction

endpackage

// File: rtl/cell_test_sequencer_if.sv
// Header pins plus run control/status of the cell test sequencer.
interface cell_test_sequencer_if;
    logic        start;
    logic [64:1] pin_out;
    logic [64:1] pin_oe;
    logic [64:1] pin_in;
    logic        busy;
    logic        done;
    logic        pass;
    logic [6:0]  err_count;
    logic [4:0]  fail_slot;
    logic [3:0]  fail_vec;

    modport master (output start, pin_in,
                    input  pin_out, pin_oe, busy, done, pass, err_count, fail_slot, fail_vec);
    modport slave  (input  start, pin_in,
                    output pin_out, pin_oe, busy, done, pass, err_count, fail_slot, fail_vec);
endinterface

// File: rtl/celltest_sync.sv
// Two-flop synchronizer for the asynchronous header read-back pins.
module celltest_sync (
    input  logic        clk,
    input  logic        rst,
    input  logic [64:1] d,
    output logic [64:1] q
);
    logic [64:1] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/cell_test_sequencer.sv
// Exhaustive gate tester for the RV523 cell board.
// Optional macro CELLTEST_STOP_ON_FAIL_EN ends the run at the first mismatch.
module cell_test_sequencer #(
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    cell_test_sequencer_if.slave  bus
);
    import celltest_pkg::*;

    localparam int          CW      = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [64:1] IN_MASK = input_mask();

    typedef enum logic [2:0] {S_IDLE, S_APPLY, S_SETTLE, S_CHECK, S_DONE} state_t;

    state_t      state;
    logic [4:0]  slot;
    logic [3:0]  vec;
    logic [CW-1:0] cnt;
    logic [64:1] pin_out;
    logic [64:1] pin_sync;
    logic        busy, done, pass;
    logic [6:0]  err_count;
    logic [4:0]  fail_slot;
    logic [3:0]  fail_vec;

    celltest_sync u_sync (.clk(clk), .rst(rst), .d(bus.pin_in), .q(pin_sync));

    slot_t      cur;
    logic       mismatch, last_vec, last_slot, finish;
    logic [6:0] err_next;

    assign cur       = SLOT_TAB[slot];
    assign mismatch  = pin_sync[cur.out_pin] != expected_out(cur.ctype, cur.n_inputs, vec);
    assign last_vec  = vec == ((4'd1 << cur.n_inputs) - 4'd1);
    assign last_slot = slot == 5'(NUM_SLOTS - 1);
    assign err_next  = err_count + {6'd0, mismatch};
`ifdef CELLTEST_STOP_ON_FAIL_EN
    assign finish    = mismatch || (last_vec && last_slot);
`else
    assign finish    = last_vec && last_slot;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            slot      <= '0;
            vec       <= '0;
            cnt       <= '0;
            pin_out   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_slot <= '0;
            fail_vec  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (bus.start) begin
                    err_count <= '0;
                    fail_slot <= '0;
                    fail_vec  <= '0;
                    pass      <= 1'b0;
                    slot      <= '0;
                    vec       <= '0;
                    busy      <= 1'b1;
                    state     <= S_APPLY;
                end
                S_APPLY: begin
                    pin_out <= vec_drive(cur.in_pin, cur.n_inputs, vec);
                    cnt     <= CW'(SETTLE_CYCLES - 1);
                    state   <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (cnt == '0) state <= S_CHECK;
                    else           cnt   <= cnt - 1'b1;
                end
                S_CHECK: begin
                    if (mismatch) begin
                        err_count <= err_next;
                        if (err_count == '0) begin
                            fail_slot <= slot;
                            fail_vec  <= vec;
                        end
                    end
                    if (finish) begin
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                        state <= S_DONE;
                    end else begin
                        if (last_vec) begin
                            slot <= slot + 5'd1;
                            vec  <= '0;
                        end else begin
                            vec  <= vec + 4'd1;
                        end
                        state <= S_APPLY;
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    pin_out <= '0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Enables follow the registered busy flag, so rst drops them at once.
    assign bus.pin_oe    = busy ? IN_MASK : '0;
    assign bus.pin_out   = pin_out;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.pass      = pass;
    assign bus.err_count = err_count;
    assign bus.fail_slot = fail_slot;
    assign bus.fail_vec  = fail_vec;
endmodule

// File: tb/tb_cell_test_sequencer.sv
// Scoreboard bench: a pin-level board model with injectable faults, a run-level predictor and a done monitor.
module tb_cell_test_sequencer;
    localparam int SETTLE  = 16;
    localparam int VEC_CLK = SETTLE + 2;

    logic clk = 1'b0;
    logic rst;
    cell_test_sequencer_if bus();

    cell_test_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct { int err; int slot; int vec; int pass; int lat; } exp_t;
    exp_t sb[$];

    int tests = 0, fails = 0;
    int cyc = 0, start_cyc = 0, done_seen = 0;
    int prev_busy = 0, oe_bad = 0, out_bad = 0;
    int mode [17];           // 0 good, 1 stuck-0, 2 stuck-1, 3 inverted output
    logic [64:1] noise = '0;

    // Board geometry straight from the pin list
    function automatic int nin(int s);
        if (s < 4) return 1;
        if (s < 12) return 2;
        if (s < 16) return 3;
        return 4;
    endfunction
    function automatic int base(int s);
        if (s < 4)  return 1 + 2 * s;
        if (s < 8)  return 9 + 3 * (s - 4);
        if (s < 12) return 21 + 3 * (s - 8);
        if (s < 14) return 33 + 4 * (s - 12);
        if (s < 16) return 41 + 4 * (s - 14);
        return 49;
    endfunction
    function automatic bit is_nand(int s);
        return (s >= 4 && s < 8) || s == 12 || s == 13 || s == 16;
    endfunction
    // NOT and NOR both output 1 only for the all-zero vector
    function automatic bit ideal(int s, int v);
        if (is_nand(s)) return v != (1 << nin(s)) - 1;
        return v == 0;
    endfunction
    function automatic bit faulty(int s, bit i);
        case (mode[s])
            1: return 1'b0;
            2: return 1'b1;
            3: return !i;
            default: return i;
        endcase
    endfunction
    function automatic logic [64:1] tb_mask();
        logic [64:1] m;
        m = '0;
        for (int s = 0; s < 17; s++)
            for (int i = 0; i < nin(s); i++) m[base(s) + i] = 1'b1;
        return m;
    endfunction
    // Undriven inputs float high on the board
    function automatic bit board_out(int s, logic [64:1] po, logic [64:1] oe);
        int v;
        v = 0;
        for (int i = 0; i < nin(s); i++)
            if (oe[base(s) + i] ? po[base(s) + i] : 1'b1) v = v | (1 << i);
        return faulty(s, ideal(s, v));
    endfunction

    always_comb begin
        bus.pin_in = noise;
        for (int s = 0; s < 17; s++)
            bus.pin_in[base(s) + nin(s)] = board_out(s, bus.pin_out, bus.pin_oe);
    end

    function automatic exp_t predict();
        exp_t e;
        int idx;
        bit stop;
        e.err = 0; e.slot = 0; e.vec = 0; e.lat = 88 * VEC_CLK;
        idx = 0; stop = 0;
        for (int s = 0; s < 17; s++)
            for (int v = 0; v < (1 << nin(s)); v++)
                if (!stop) begin
                    if (faulty(s, ideal(s, v)) != ideal(s, v)) begin
                        if (e.err == 0) begin e.slot = s; e.vec = v; end
                        e.err++;
`ifdef CELLTEST_STOP_ON_FAIL_EN
                        stop  = 1;
                        e.lat = (idx + 1) * VEC_CLK;
`endif
                    end
                    idx++;
                end
        e.pass = (e.err == 0) ? 1 : 0;
        return e;
    endfunction

    task automatic check(string name, longint act, longint expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: tracks run start, watches pin discipline, scores each done pulse
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.busy && prev_busy == 0) begin
                start_cyc = cyc; oe_bad = 0; out_bad = 0;
            end
            if (bus.busy && bus.pin_oe !== tb_mask()) oe_bad = 1;
            if ((bus.pin_out & ~tb_mask()) != '0) out_bad = 1;
            if (bus.done) begin
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_done: got done with empty scoreboard, expected none");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("err_count", bus.err_count, e.err);
                    check("fail_slot", bus.fail_slot, e.slot);
                    check("fail_vec",  bus.fail_vec,  e.vec);
                    check("pass",      bus.pass,      e.pass);
                    check("latency",   cyc - start_cyc, e.lat);
                    check("pin_oe_while_busy", oe_bad, 0);
                    check("pin_out_undriven_pins", out_bad, 0);
                end
                done_seen++;
            end
        end
        prev_busy = bus.busy;
    end

    task automatic set_modes(int kind);
        for (int s = 0; s < 17; s++)
            mode[s] = (kind == 1) ? 1 :
                      (kind == 2) ? (($urandom_range(0, 7) > 5) ? int'($urandom_range(1, 3)) : 0) : 0;
    endtask

    task automatic run(bit mid_start);
        exp_t e;
        int seen, t;
        noise = {$urandom, $urandom};
        e = predict();
        sb.push_back(e);
        seen = done_seen;
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        if (mid_start) begin
            repeat (5 * VEC_CLK) @(negedge clk);
            bus.start = 1'b1;
            @(negedge clk) bus.start = 1'b0;
        end
        t = 0;
        while (done_seen == seen && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (done_seen == seen) begin
            tests++; fails++;
            $display("FAIL run_timeout: got no done after %0d cycles, expected done", t);
            if (sb.size() > 0) void'(sb.pop_front());
        end
        repeat (3) @(negedge clk);
        check("pass_held", bus.pass, e.pass);
        check("err_count_held", bus.err_count, e.err);
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        set_modes(0);
        repeat (3) @(negedge clk);
        check("rst_pin_out", bus.pin_out, 0);
        check("rst_pin_oe", bus.pin_oe, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_pass", bus.pass, 0);
        check("rst_err_count", bus.err_count, 0);
        check("rst_fail_slot", bus.fail_slot, 0);
        check("rst_fail_vec", bus.fail_vec, 0);
        rst = 1'b0;
        @(negedge clk);

        run(0);                                  // ideal board
        set_modes(0); mode[4] = 2; run(0);       // pin 11 stuck at 1
        set_modes(1); run(0);                    // every output stuck at 0
        set_modes(0); run(1);                    // stray start mid-run

        // Reset around vector 40, then a fresh run
        set_modes(0);
        sb.push_back(predict());
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        repeat (40 * VEC_CLK) @(negedge clk);
        check("busy_before_rst", bus.busy, 1);
        #2 rst = 1'b1;
        #1;
        check("midrst_pin_oe", bus.pin_oe, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_pin_out", bus.pin_out, 0);
        check("midrst_err_count", bus.err_count, 0);
        void'(sb.pop_front());
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        run(0);

        for (int r = 0; r < 4; r++) begin
            set_modes(2);
            run(0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cell_test_sequencer.md
# cell_test_sequencer

FPGA-side tester that sits directly upstream of the RV523 cell test board and plugs into its 2x32 header. It drives exhaustive input vectors into every gate instance on the board (4 NOT, 4 NAND2, 4 NOR2, 2 NAND3, 2 NOR3, 1 NAND4). After a programmable settle time it samples each gate output through a synchronizer and compares it against the ideal logic function. It reports pass/fail, a mismatch count, and the first failing slot and vector.

## Interface
Parameters:
- SETTLE_CYCLES, 16, clocks between applying a vector and sampling the output; must be ≥ 3.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a run; sampled only in IDLE
- pin_out  out  [64:1]  value driven toward header pin n
- pin_oe  out  [64:1]  output enable for pin n; 0 means high-Z
- pin_in  in  [64:1]  raw (asynchronous) level read back from header pin n
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- pass  out  1  1 if the last run had zero mismatches; held until the next start
- err_count  out  7  mismatch count of the last run (maximum 88)
- fail_slot  out  5  slot index of the first mismatch
- fail_vec  out  4  vector of the first mismatch

## Operation
- Slots are numbered in this order:
  - 0–3 NOT on pins (A,Y) = (1,2), (3,4), (5,6), (7,8)
  - 4–7 NAND2 on (A1,A2,Y) = (9,10,11), (12,13,14), (15,16,17), (18,19,20)
  - 8–11 NOR2 on (21,22,23), (24,25,26), (27,28,29), (30,31,32)
  - 12–13 NAND3 on (33,34,35,36), (37,38,39,40)
  - 14–15 NOR3 on (41,42,43,44), (45,46,47,48)
  - 16 NAND4 on (49,50,51,52,53)
- Vectors per slot with k inputs run 0..2^k−1; vector bit i drives input A(i+1). Total is 88 vectors.
- Expected output values:
  - NOT: ~A
  - NAND: ~&inputs
  - NOR: ~|inputs
- pin_oe is 1 on every gate-input pin while busy and 0 otherwise. Gate-output pins and pins 54–64 always have pin_oe = 0.
- pin_out: the active slot's inputs carry the current vector; all other driven pins carry 0.
- pin_in passes through a 2-flop synchronizer before it is compared.
- FSM states:
  - IDLE: on start=1, clear err_count, fail_slot, fail_vec and pass, then go to APPLY at slot 0, vector 0.
  - APPLY: one cycle; update pin_out; load the settle counter; go to SETTLE.
  - SETTLE: hold for SETTLE_CYCLES cycles, then go to CHECK.
  - CHECK: compare the synchronized output pin with the expected value.
    - On mismatch, increment err_count. If this is the first mismatch, latch fail_slot and fail_vec.
    - If this was the last vector of the last slot, go to DONE.
    - Otherwise advance the vector, or wrap to vector 0 of the next slot, and go to APPLY.
  - DONE: pulse done; set pass = (err_count == 0); go to IDLE.
- start while busy is ignored. start held high in IDLE restarts the run in the cycle after DONE.

## Timing
- Reset values: pin_out 0, pin_oe 0, busy 0, done 0, pass 0, err_count 0, fail_slot 0, fail_vec 0; FSM in IDLE.
- Asserting rst mid-run returns every output to its reset value asynchronously, so all pins go high-Z at once.
- busy rises on the clock edge that accepts start and falls on the edge that enters IDLE after DONE.
- Each vector takes SETTLE_CYCLES + 2 clocks. A full run takes 88·(SETTLE_CYCLES + 2) clocks from the start edge, and done is asserted in the following cycle.

## Configuration
- CELLTEST_STOP_ON_FAIL_EN:
  - Defined: the first mismatch in CHECK goes directly to DONE. err_count is then 1 and pass is 0.
  - Undefined: all 88 vectors always run, and every mismatch is counted.

## Structure
- Package celltest_pkg contains:
  - cell-type enum (CT_NOT, CT_NAND, CT_NOR)
  - slot struct {type, n_inputs, in_pin[4], out_pin}
  - constant slot table and the NUM_SLOTS = 17 and NUM_VECTORS = 88 constants
  - expected-output function
- Sub-module celltest_sync is the 64-bit, 2-flop synchronizer for pin_in.

## Test plan
- Ideal board model, SETTLE_CYCLES = 16: done at clock 1584 after start; pass = 1; err_count = 0.
- Pin 11 stuck at 1: err_count = 1, fail_slot = 4, fail_vec = 3, pass = 0.
- All output pins stuck at 0: err_count = 51, fail_slot = 0, fail_vec = 0.
- Pin 11 stuck at 1 with CELLTEST_STOP_ON_FAIL_EN defined: done after 12·18 = 216 clocks; err_count = 1.
- start pulsed at vector 5 is ignored, so the run length is unchanged.
- rst asserted at vector 40: pin_oe = 0 and busy = 0 immediately; a fresh start then completes normally.
